systolic_array_sequencer: RTL and testbench
===========================================

Name: systolic_array_sequencer

Overview:
- Control-side counterpart to the systolic datapath.
- Reads the datapath's tensor/weight FIFOs with the diagonal skew the PE grid needs, and gates mac_en during compute.
- Afterwards drains the SIZE x SIZE result grid through the out_en/out_rsel/out_csel read port, emitting it as a val/rdy stream in row-major order.
- One sequencer sits beside each systolic datapath instance.

Parameters:
- SIZE, 4: array dimension; FIFO depth and inner-product length K = SIZE.
- NBITS, 16: data width of b_s_out / res_msg.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start_val  in  1  request one matrix multiply
- start_rdy  out  1  sequencer can accept start
- x_fifo_empty  in  [SIZE]  tensor FIFO empty flags
- w_fifo_empty  in  [SIZE]  weight FIFO empty flags
- x_fifo_ren  out  [SIZE]  tensor FIFO read enables
- w_fifo_ren  out  [SIZE]  weight FIFO read enables
- mac_en  out  1  PE accumulate enable
- out_en  out  1  datapath result read enable
- out_rsel  out  $clog2(SIZE)  result row select
- out_csel  out  $clog2(SIZE)  result column select
- b_s_out  in  NBITS  selected result from datapath
- res_val  out  1  result beat valid
- res_rdy  in  1  downstream ready
- res_msg  out  NBITS  result value
- res_last  out  1  final beat (row SIZE-1, col SIZE-1)
- busy  out  1  not IDLE

Behaviour:
- Reset: async on rst=0. State=IDLE, counters=0. All outputs 0 except start_rdy=1.
- States: IDLE -> COMPUTE -> DRAIN -> IDLE.
- IDLE:
  - start_rdy=1.
  - Handshake start_val&&start_rdy -> COMPUTE; cycle counter c=0.
  - Nothing else driven.
- COMPUTE:
  - Scheduled reads: sched_x[i] = (c>=i)&&(c<i+SIZE); sched_w[j] identical in j.
  - stall = OR over k of (sched_x[k]&&x_fifo_empty[k]) | (sched_w[k]&&w_fifo_empty[k]).
  - Not stalled: x_fifo_ren=sched_x, w_fifo_ren=sched_w, mac_en=1, c increments.
  - Stalled: all ren=0, mac_en=0, c holds. The stall is global, so skew is preserved.
  - Length: COMPUTE_CYCLES = 3*SIZE-1 unstalled cycles (K + 2*(SIZE-1) + 1 FIFO read latency).
  - When c==COMPUTE_CYCLES-1 and not stalled -> DRAIN, with r=0, col=0.
  - start_rdy=0.
- DRAIN:
  - out_en=1, out_rsel=r, out_csel=col.
  - res_msg=b_s_out (combinational passthrough). res_val=1. res_last=(r==SIZE-1&&col==SIZE-1).
  - On res_val&&res_rdy: col++; on col wrap to 0, r++.
  - On the last handshake -> IDLE.
  - res_rdy=0: r/col hold and res_msg stays stable.
  - mac_en=0, all ren=0.
- Outputs: res_val/out_en are 0 outside DRAIN; mac_en/ren are 0 outside COMPUTE.
- busy=1 in COMPUTE and DRAIN.
- start_val is ignored while busy. No queuing: start is re-sampled only in IDLE.
- Counter widths: c is $clog2(3*SIZE) bits; r/col are $clog2(SIZE) bits. No counter passes its terminal value.
- Reset mid-COMPUTE or mid-DRAIN: immediate return to IDLE, outputs at reset values. The datapath accumulators are not cleared here; they are cleared by the shared reset.
- A start in the same cycle as the final DRAIN handshake is not accepted; it is taken the following cycle in IDLE.

Optional Feature:
- Macro: SYSTOLIC_SEQ_TAG_EN.
- Defined: adds outputs res_row and res_col, each $clog2(SIZE) bits, equal to r and col and valid with res_val. Also adds output stall_cnt, 16 bits: saturating count of stalled COMPUTE cycles, cleared on start handshake.
- Undefined: these ports and this logic do not exist. Everything else is identical.

Test Plan:
- Reset, then start with all FIFOs non-empty and res_rdy=1 (SIZE=4):
  - start_rdy=0 the cycle after the handshake.
  - mac_en high for exactly 11 consecutive cycles.
  - x_fifo_ren[0] high for c=0..3; x_fifo_ren[3] high for c=3..6; same pattern for w.
  - Then 16 res beats with out_rsel/out_csel stepping (0,0),(0,1)..(3,3); res_last only on beat 16; busy drops after it.
- Drive x_fifo_empty[2]=1 for 3 cycles at c=2:
  - ren and mac_en drop to 0 for exactly 3 cycles, c holds.
  - Total COMPUTE length is 14 cycles; ren skew is unchanged.
- During DRAIN, hold res_rdy=0 for 5 cycles at beat (1,2):
  - res_val stays 1, out_rsel=1, out_csel=2, res_msg stable.
  - Resume yields exactly 16 beats with no duplicates or skips.
- Pulse rst=0 mid-DRAIN at beat (2,1):
  - Same cycle: res_val=0, out_en=0, start_rdy=1.
  - Next start performs the full 11-cycle COMPUTE and 16-beat DRAIN.
- start_val held high through a whole operation: exactly one operation per IDLE visit; the second starts one cycle after the final DRAIN beat.
- With SYSTOLIC_SEQ_TAG_EN: res_row/res_col match the selects on every beat; stall_cnt=3 after the stall scenario and resets to 0 on the next start.

Source files
------------

// File: rtl/systolic_array_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_array_sequencer
//
// Control-side companion of one systolic datapath instance. On a start
// handshake it reads the tensor (x) and weight (w) FIFOs with the diagonal
// skew the PE grid needs and enables the PE accumulators. It then drains the
// SIZE x SIZE result grid, row-major, as a val/rdy stream.
//
// Optional feature (macro SYSTOLIC_SEQ_TAG_EN): adds res_row/res_col beat
// tags and a 16-bit saturating stall_cnt of stalled compute cycles.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start_val/rdy       start request handshake (accepted only when idle)
//   x/w_fifo_empty      per-lane FIFO empty flags from the datapath
//   x/w_fifo_ren        per-lane FIFO read enables
//   mac_en              PE accumulate enable
//   out_en/rsel/csel    datapath result read port
//   b_s_out             selected result value from the datapath
//   res_val/rdy/msg     result stream; res_last marks beat (SIZE-1,SIZE-1)
//   busy                high whenever an operation is in progress
// ---------------------------------------------------------------------------
module systolic_array_sequencer #(
    parameter int SIZE  = 4,
    parameter int NBITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_val,
    output logic                     start_rdy,
    input  logic [SIZE-1:0]          x_fifo_empty,
    input  logic [SIZE-1:0]          w_fifo_empty,
    output logic [SIZE-1:0]          x_fifo_ren,
    output logic [SIZE-1:0]          w_fifo_ren,
    output logic                     mac_en,
    output logic                     out_en,
    output logic [$clog2(SIZE)-1:0]  out_rsel,
    output logic [$clog2(SIZE)-1:0]  out_csel,
    input  logic [NBITS-1:0]         b_s_out,
    output logic                     res_val,
    input  logic                     res_rdy,
    output logic [NBITS-1:0]         res_msg,
    output logic                     res_last,
`ifdef SYSTOLIC_SEQ_TAG_EN
    output logic [$clog2(SIZE)-1:0]  res_row,
    output logic [$clog2(SIZE)-1:0]  res_col,
    output logic [15:0]              stall_cnt,
`endif
    output logic                     busy
);

    localparam int CW = $clog2(3 * SIZE);
    localparam int SW = $clog2(SIZE);

    // K inner-product steps + 2*(SIZE-1) skew + 1 FIFO read latency
    localparam logic [CW-1:0] C_LAST = CW'(3 * SIZE - 2);
    localparam logic [SW-1:0] IDX_LAST = SW'(SIZE - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]     state_reg;
    logic [CW-1:0]  c_reg;
    logic [SW-1:0]  r_reg;
    logic [SW-1:0]  col_reg;
    logic [SIZE-1:0] sched;
    logic           in_idle;
    logic           in_compute;
    logic           in_drain;
    logic           stall;
    logic           beat_fire;
    logic           last_beat;

    assign in_idle    = (state_reg == ST_IDLE);
    assign in_compute = (state_reg == ST_COMPUTE);
    assign in_drain   = (state_reg == ST_DRAIN);

    // Lane gi is read during a window of SIZE cycles starting at c == gi.
    // The x and w schedules are identical, so one vector serves both.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_sched
            localparam logic [CW-1:0] LO = CW'(gi);
            localparam logic [CW-1:0] HI = CW'(gi + SIZE);
            assign sched[gi] = (c_reg >= LO) && (c_reg < HI);
        end
    endgenerate

    // Any scheduled lane that is empty freezes every lane, preserving skew.
    assign stall     = in_compute &&
                       (|((sched & x_fifo_empty) | (sched & w_fifo_empty)));
    assign beat_fire = in_drain && res_rdy;
    assign last_beat = (r_reg == IDX_LAST) && (col_reg == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            c_reg     <= '0;
            r_reg     <= '0;
            col_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_val) begin
                        state_reg <= ST_COMPUTE;
                        c_reg     <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (!stall) begin
                        if (c_reg == C_LAST) begin
                            state_reg <= ST_DRAIN;
                            c_reg     <= '0;
                            r_reg     <= '0;
                            col_reg   <= '0;
                        end else begin
                            c_reg <= c_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (beat_fire) begin
                        if (col_reg == IDX_LAST) begin
                            col_reg <= '0;
                            if (r_reg == IDX_LAST) begin
                                r_reg     <= '0;
                                state_reg <= ST_IDLE;
                            end else begin
                                r_reg <= r_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign start_rdy  = in_idle;
    assign busy       = !in_idle;
    assign mac_en     = in_compute && !stall;
    assign x_fifo_ren = mac_en ? sched : '0;
    assign w_fifo_ren = mac_en ? sched : '0;
    assign out_en     = in_drain;
    assign res_val    = in_drain;
    assign out_rsel   = in_drain ? r_reg : '0;
    assign out_csel   = in_drain ? col_reg : '0;
    assign res_msg    = in_drain ? b_s_out : '0;
    assign res_last   = in_drain && last_beat;

`ifdef SYSTOLIC_SEQ_TAG_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (in_idle && start_val) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign res_row   = out_rsel;
    assign res_col   = out_csel;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// ---------------------------------------------------------------------------
// Directed bench for systolic_array_sequencer with SIZE=4, NBITS=16.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// Covers: reset state, plain operation, compute stall, drain backpressure,
// reset in the middle of drain, and start_val held across an operation.
// Build with +define+SYSTOLIC_SEQ_TAG_EN to include the tag/stall checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systolic_array_sequencer;

    localparam int SIZE  = 4;
    localparam int NBITS = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_val;
    logic              start_rdy;
    logic [SIZE-1:0]   x_fifo_empty;
    logic [SIZE-1:0]   w_fifo_empty;
    logic [SIZE-1:0]   x_fifo_ren;
    logic [SIZE-1:0]   w_fifo_ren;
    logic              mac_en;
    logic              out_en;
    logic [1:0]        out_rsel;
    logic [1:0]        out_csel;
    logic [NBITS-1:0]  b_s_out;
    logic              res_val;
    logic              res_rdy;
    logic [NBITS-1:0]  res_msg;
    logic              res_last;
    logic              busy;
`ifdef SYSTOLIC_SEQ_TAG_EN
    logic [1:0]        res_row;
    logic [1:0]        res_col;
    logic [15:0]       stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Expected read-enable pattern per unstalled compute step (SIZE=4).
    logic [3:0] ren_tab [11] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0000};

    systolic_array_sequencer #(.SIZE(SIZE), .NBITS(NBITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_val    (start_val),
        .start_rdy    (start_rdy),
        .x_fifo_empty (x_fifo_empty),
        .w_fifo_empty (w_fifo_empty),
        .x_fifo_ren   (x_fifo_ren),
        .w_fifo_ren   (w_fifo_ren),
        .mac_en       (mac_en),
        .out_en       (out_en),
        .out_rsel     (out_rsel),
        .out_csel     (out_csel),
        .b_s_out      (b_s_out),
        .res_val      (res_val),
        .res_rdy      (res_rdy),
        .res_msg      (res_msg),
        .res_last     (res_last),
`ifdef SYSTOLIC_SEQ_TAG_EN
        .res_row      (res_row),
        .res_col      (res_col),
        .stall_cnt    (stall_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while idle; returns at the falling edge of
    // the first compute cycle. hold keeps start_val asserted.
    task automatic start_op(input bit hold);
        start_val = 1'b1;
        #1;
        chk("idle_start_rdy", 32'(start_rdy), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        if (!hold) start_val = 1'b0;
        #1;
        chk("post_hs_start_rdy", 32'(start_rdy), 32'd0);
        chk("post_hs_busy", 32'(busy), 32'd1);
`ifdef SYSTOLIC_SEQ_TAG_EN
        chk("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
`endif
    endtask

    // Runs the compute phase, optionally stalling lane 2 for stall_len
    // cycles once step 2 is reached. Ends at the falling edge of drain beat 0.
    task automatic do_compute(input int stall_len);
        int cidx = 0;
        int nstall = 0;
        int cycles = 0;
        int macs = 0;
        bit stalled;
        while (cidx < 11 && cycles < 40) begin
            stalled = (stall_len > 0) && (cidx == 2) && (nstall < stall_len);
            x_fifo_empty = stalled ? 4'b0100 : 4'b0000;
            #1;
            if (stalled) begin
                chk("stall_mac_en", 32'(mac_en), 32'd0);
                chk("stall_x_ren", 32'(x_fifo_ren), 32'd0);
                chk("stall_w_ren", 32'(w_fifo_ren), 32'd0);
                nstall++;
            end else begin
                chk($sformatf("mac_en_c%0d", cidx), 32'(mac_en), 32'd1);
                chk($sformatf("x_ren_c%0d", cidx), 32'(x_fifo_ren), 32'(ren_tab[cidx]));
                chk($sformatf("w_ren_c%0d", cidx), 32'(w_fifo_ren), 32'(ren_tab[cidx]));
                macs++;
                cidx++;
            end
            chk("compute_res_val", 32'(res_val), 32'd0);
            cycles++;
            @(negedge clk);
        end
        x_fifo_empty = 4'b0000;
        chk("compute_cycles", 32'(cycles), 32'(11 + stall_len));
        chk("compute_mac_cycles", 32'(macs), 32'd11);
        $display("[TB] compute done: %0d cycles, %0d stalled", cycles, nstall);
    endtask

    // Drains the result grid. hold_beat/hold_len apply res_rdy=0 backpressure;
    // rst_beat (if >= 0) pulses reset while that beat is presented.
    task automatic do_drain(input int hold_beat, input int hold_len, input int rst_beat);
        int beat = 0;
        int nhold = 0;
        int guard = 0;
        bit rdy;
        while (beat < 16 && guard < 64) begin
            rdy = !((beat == hold_beat) && (nhold < hold_len));
            res_rdy = rdy;
            b_s_out = 16'hC000 + 16'(beat);
            if (beat == rst_beat) begin
                rst = 1'b0;
                #1;
                chk("rst_res_val", 32'(res_val), 32'd0);
                chk("rst_out_en", 32'(out_en), 32'd0);
                chk("rst_start_rdy", 32'(start_rdy), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                $display("[TB] reset applied at beat %0d", beat);
                @(negedge clk);
                rst = 1'b1;
                res_rdy = 1'b1;
                return;
            end
            #1;
            chk($sformatf("res_val_b%0d", beat), 32'(res_val), 32'd1);
            chk($sformatf("out_en_b%0d", beat), 32'(out_en), 32'd1);
            chk($sformatf("rsel_b%0d", beat), 32'(out_rsel), 32'(beat / 4));
            chk($sformatf("csel_b%0d", beat), 32'(out_csel), 32'(beat % 4));
            chk($sformatf("res_msg_b%0d", beat), 32'(res_msg), 32'(16'hC000 + 16'(beat)));
            chk($sformatf("res_last_b%0d", beat), 32'(res_last), 32'(beat == 15));
            chk($sformatf("drain_mac_b%0d", beat), 32'(mac_en), 32'd0);
            chk($sformatf("drain_ren_b%0d", beat), 32'(x_fifo_ren | w_fifo_ren), 32'd0);
`ifdef SYSTOLIC_SEQ_TAG_EN
            chk($sformatf("res_row_b%0d", beat), 32'(res_row), 32'(beat / 4));
            chk($sformatf("res_col_b%0d", beat), 32'(res_col), 32'(beat % 4));
`endif
            if (rdy) beat++;
            else nhold++;
            guard++;
            @(negedge clk);
        end
        res_rdy = 1'b1;
        chk("drain_beats", 32'(beat), 32'd16);
        chk("drain_cycles", 32'(guard), 32'(16 + hold_len));
        #1;
        chk("after_drain_busy", 32'(busy), 32'd0);
        chk("after_drain_start_rdy", 32'(start_rdy), 32'd1);
        chk("after_drain_res_val", 32'(res_val), 32'd0);
        $display("[TB] drain done: %0d beats in %0d cycles", beat, guard);
    endtask

    initial begin
        rst = 1'b0;
        start_val = 1'b0;
        x_fifo_empty = '0;
        w_fifo_empty = '0;
        b_s_out = '0;
        res_rdy = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_start_rdy", 32'(start_rdy), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mac_en", 32'(mac_en), 32'd0);
        chk("reset_out_en", 32'(out_en), 32'd0);
        chk("reset_res_val", 32'(res_val), 32'd0);
        chk("reset_ren", 32'(x_fifo_ren | w_fifo_ren), 32'd0);
        chk("reset_res_last", 32'(res_last), 32'd0);
`ifdef SYSTOLIC_SEQ_TAG_EN
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");

        // Plain operation
        start_op(1'b0);
        do_compute(0);
        do_drain(-1, 0, -1);

        // Stall of 3 cycles at step 2
        @(negedge clk);
        start_op(1'b0);
        do_compute(3);
        do_drain(-1, 0, -1);
`ifdef SYSTOLIC_SEQ_TAG_EN
        chk("stall_cnt_after_stall", 32'(stall_cnt), 32'd3);
`endif

        // Backpressure: res_rdy low for 5 cycles at beat (1,2)
        @(negedge clk);
        start_op(1'b0);
        do_compute(0);
        do_drain(6, 5, -1);

        // Reset pulse at beat (2,1), then a full operation
        @(negedge clk);
        start_op(1'b0);
        do_compute(0);
        do_drain(-1, 0, 9);
        @(negedge clk);
        start_op(1'b0);
        do_compute(0);
        do_drain(-1, 0, -1);

        // start_val held through two back-to-back operations
        @(negedge clk);
        start_op(1'b1);
        do_compute(0);
        do_drain(-1, 0, -1);
        @(negedge clk);
        #1;
        chk("held_restart_busy", 32'(busy), 32'd1);
        chk("held_restart_mac_en", 32'(mac_en), 32'd1);
        chk("held_restart_start_rdy", 32'(start_rdy), 32'd0);
        start_val = 1'b0;
        do_compute(0);
        do_drain(-1, 0, -1);
        @(negedge clk);
        #1;
        chk("final_idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
